// File: rtl/adc_pkg.sv
// Shared definitions for the ADC burst packer: word layout, framing magics,
// FIFO entry format and output-FSM state encoding.
package adc_pkg;

    localparam int IDX_W   = 49;
    localparam int SUM_W   = 15;
    localparam int DATA_W  = 64;
    localparam int ENTRY_W = DATA_W + 2;

    // Capture word layout: {sample_index, sum_abs}
    localparam int SUM_LSB = 0;
    localparam int SUM_MSB = SUM_LSB + SUM_W - 1;
    localparam int IDX_LSB = SUM_MSB + 1;
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;

    // FIFO entry layout: {start, eob, data}
    localparam int ENT_EOB_BIT   = DATA_W;
    localparam int ENT_START_BIT = DATA_W + 1;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [7:0] TRL_MAGIC = 8'h5A;

    // eob marks an end-of-burst marker entry (data is zero)
    typedef struct packed {
        logic              start;
        logic              eob;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_TRL
    } out_state_t;

    function automatic logic [DATA_W-1:0] hdr_word(input logic [IDX_W-1:0] idx);
        return {HDR_MAGIC, 7'd0, idx};
    endfunction

    function automatic logic [DATA_W-1:0] trl_word(input logic [31:0] cnt);
        return {TRL_MAGIC, 24'd0, cnt};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout whenever
// empty is low. Pushes when full and pops when empty are ignored.
module sync_fifo_fwft #(
    parameter int W  = 66,
    parameter int AW = 10
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write
    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge aclk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/adc_burst_packer.sv
// Packs the ADC capture stream into framed bursts (header, samples, trailer).
// The input side classifies beats and closes idle bursts with an end marker;
// the output side walks the FIFO and frames each run for the DMA writer.
module adc_burst_packer
    import adc_pkg::*;
#(
    parameter int FIFO_AW      = 10,
    parameter int IDLE_TIMEOUT = 16,
    parameter int MAX_BURST    = 2000000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [15:0] bursts_done,
    output logic [31:0] drop_count,
    output logic        busy
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    // Input side state
    logic              ready_en;     // keeps tready low until the first edge after reset
    logic              burst_open;
    logic              marker_pend;  // timed-out marker waiting for FIFO space
    logic [IDX_W-1:0]  exp_idx;
    logic [31:0]       run_len;
    logic [IDLE_W-1:0] idle_cnt;

    logic              beat_acc;
    logic              beat_start;
    logic [IDX_W-1:0]  beat_idx;
    logic              timeout_hit;
    logic              marker_push;

    // FIFO interface
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    entry_t             wr_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] head_raw;

    // Output side state
    out_state_t  state;
    out_state_t  state_nx;
    logic [31:0] count;
    logic [31:0] count_nx;
    logic        first_smp;
    logic        first_nx;
    logic        trl_done;

    assign head = entry_t'(head_raw);
    assign busy = burst_open || !fifo_empty;

    // Beat acceptance, burst classification and end-marker arbitration
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    always_comb begin
        s_axis_tready = ready_en && !fifo_full && !marker_pend;
        beat_acc      = s_axis_tvalid && s_axis_tready;
        beat_idx      = s_axis_tdata[IDX_MSB:IDX_LSB];
        beat_start    = !burst_open || (beat_idx != exp_idx) || (run_len == 32'(MAX_BURST));
        // An accepted beat in the timeout cycle cancels the timeout
        timeout_hit   = burst_open && !marker_pend && !beat_acc &&
                        (idle_cnt == IDLE_W'(IDLE_TIMEOUT));
        marker_push   = (timeout_hit || marker_pend) && !fifo_full;
        fifo_push     = beat_acc || marker_push;
        wr_entry      = '{start: 1'b0, eob: 1'b1, data: '0};
        if (beat_acc) begin
            wr_entry = '{start: beat_start, eob: 1'b0, data: s_axis_tdata};
        end
    end

    // Input side registers: burst tracking, idle timer, drop counter
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_en    <= 1'b0;
            burst_open  <= 1'b0;
            marker_pend <= 1'b0;
            exp_idx     <= '0;
            run_len     <= '0;
            idle_cnt    <= '0;
            drop_count  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (beat_acc) begin
                burst_open <= 1'b1;
                exp_idx    <= beat_idx + IDX_W'(1);
                run_len    <= beat_start ? 32'd1 : run_len + 32'd1;
                idle_cnt   <= '0;
            end else if (marker_push) begin
                burst_open  <= 1'b0;
                marker_pend <= 1'b0;
                idle_cnt    <= '0;
            end else if (timeout_hit) begin
                marker_pend <= 1'b1;
            end else if (burst_open && (idle_cnt != IDLE_W'(IDLE_TIMEOUT))) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (s_axis_tvalid && !s_axis_tready && (drop_count != '1)) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    sync_fifo_fwft #(
        .W  (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (fifo_push),
        .din    (wr_entry),
        .pop    (fifo_pop),
        .dout   (head_raw),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Output framing FSM: next state, pop and stream outputs
    always_comb begin
        state_nx      = state;
        count_nx      = count;
        first_nx      = first_smp;
        fifo_pop      = 1'b0;
        trl_done      = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head.start) begin
                        state_nx = S_HDR;
                    end else begin
                        fifo_pop = 1'b1;  // stray end marker
                    end
                end
            end
            S_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_word(head.data[IDX_MSB:IDX_LSB]);
                if (m_axis_tready) begin
                    state_nx = S_DATA;
                    count_nx = '0;
                    first_nx = 1'b1;
                end
            end
            S_DATA: begin
                if (!fifo_empty) begin
                    if (head.eob) begin
                        fifo_pop = 1'b1;
                        state_nx = S_TRL;
                    end else if (head.start && !first_smp) begin
                        state_nx = S_TRL;  // next burst's first sample stays at the head
                    end else begin
                        m_axis_tvalid = 1'b1;
                        m_axis_tdata  = head.data;
                        if (m_axis_tready) begin
                            fifo_pop = 1'b1;
                            count_nx = count + 32'd1;
                            first_nx = 1'b0;
                        end
                    end
                end
            end
            S_TRL: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = trl_word(count);
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) begin
                    trl_done = 1'b1;
                    state_nx = (!fifo_empty && head.start) ? S_HDR : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output side registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= S_IDLE;
            count       <= '0;
            first_smp   <= 1'b0;
            bursts_done <= '0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            first_smp <= first_nx;
            if (trl_done) begin
                bursts_done <= bursts_done + 16'd1;
            end
        end
    end

endmodule
